// File: rtl/control_sequencer.sv
// Hardwired control unit for CPU_Datapath. It sequences instruction fetch (T0-T2)
// and register-format execute (T3-T6). Outputs are decoded from the current state
// and the IR value returned by the datapath. Only the state is registered.
module control_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      IR,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             Read,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             ZLOin,
  output logic             ZHIin,
  output logic             ZLOout,
  output logic             ZHIout,
  output logic             HIin,
  output logic             Loin,
  output logic [OPW-1:0]   ALUSelection,
  output logic             Run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  // Instruction classes that share the same execute sequence
  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_MULDIV, CLS_UNARY, CLS_HALT
  } op_class_t;

  state_t     state, state_next;
  op_class_t  op_class;

  logic [OPW-1:0] op;
  logic [3:0]     ra, rb, rc;
  logic           unused_ir;

  assign op        = IR[31 -: OPW];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  // The low IR bits carry immediates that register-format instructions ignore
  assign unused_ir = ^IR[14:0];

  function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
    onehot = NREGS'(1) << idx;
  endfunction

  // Opcode to execute-class decode; anything unrecognised behaves as nop
  always_comb begin
    op_class = CLS_NOP;
    case (op)
      OPW'(5'b00011), OPW'(5'b00100), OPW'(5'b00101), OPW'(5'b00110),
      OPW'(5'b00111), OPW'(5'b01000), OPW'(5'b01001), OPW'(5'b01010),
      OPW'(5'b01011):                  op_class = CLS_ALU;
      OPW'(5'b01111), OPW'(5'b10000):  op_class = CLS_MULDIV;
      OPW'(5'b10001), OPW'(5'b10010):  op_class = CLS_UNARY;
      OPW'(5'b11011):                  op_class = CLS_HALT;
      default:                         op_class = CLS_NOP;
    endcase
  end

  // State register; clr returns to RESET from any state, even mid-instruction
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) state <= S_RESET;
    else     state <= state_next;
  end

  // Next-state and control-output decode from state and IR
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next   = state;
    Rin          = '0;
    Rout         = '0;
    PCout        = 1'b0;
    PCin         = 1'b0;
    IncPC        = 1'b0;
    MARin        = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    Read         = 1'b0;
    IRin         = 1'b0;
    Yin          = 1'b0;
    Zin          = 1'b0;
    ZLOin        = 1'b0;
    ZHIin        = 1'b0;
    ZLOout       = 1'b0;
    ZHIout       = 1'b0;
    HIin         = 1'b0;
    Loin         = 1'b0;
    ALUSelection = '0;
    Run          = 1'b1;

    case (state)
      S_RESET: begin
        Run        = 1'b0;
        state_next = S_T0;
      end
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; ZLOin = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        case (op_class)
          CLS_HALT: state_next = S_HALT;
          CLS_NOP:  state_next = S_T0;
          default:  state_next = S_T3;
        endcase
      end
      S_T3: begin
        state_next = S_T4;
        case (op_class)
          CLS_ALU:    begin Rout = onehot(rb); Yin = 1'b1; end
          CLS_MULDIV: begin Rout = onehot(ra); Yin = 1'b1; end
          CLS_UNARY: begin
            Rout = onehot(rb); ALUSelection = op; Zin = 1'b1; ZLOin = 1'b1;
          end
          default:    state_next = S_T0;
        endcase
      end
      S_T4: begin
        state_next = S_T5;
        case (op_class)
          CLS_ALU: begin
            Rout = onehot(rc); ALUSelection = op; Zin = 1'b1; ZLOin = 1'b1;
          end
          CLS_MULDIV: begin
            Rout = onehot(rb); ALUSelection = op; Zin = 1'b1; ZLOin = 1'b1; ZHIin = 1'b1;
          end
          CLS_UNARY: begin
            ZLOout = 1'b1; Rin = onehot(ra); state_next = S_T0;
          end
          default:    state_next = S_T0;
        endcase
      end
      S_T5: begin
        state_next = S_T0;
        case (op_class)
          CLS_ALU:    begin ZLOout = 1'b1; Rin = onehot(ra); end
          CLS_MULDIV: begin ZLOout = 1'b1; Loin = 1'b1; state_next = S_T6; end
          default:    ;
        endcase
      end
      S_T6: begin
        ZHIout = 1'b1; HIin = 1'b1;
        state_next = S_T0;
      end
      S_HALT: begin
        Run = 1'b0;
      end
      default: begin
        Run        = 1'b0;
        state_next = S_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, ALU, mul, neg, nop, undefined op,
// halt and mid-instruction clear, with a bus-contention check on every cycle.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin;
  logic Zin, ZLOin, ZHIin, ZLOout, ZHIout, HIin, Loin;
  logic [4:0]  ALUSelection;
  logic        Run;

  int total = 0;
  int bad   = 0;
  bit bus_check_en = 1'b0;

  // Single-bit controls packed as {PCout,PCin,IncPC,MARin,MDRin,MDRout,Read,IRin,
  //                                Yin,Zin,ZLOin,ZHIin,ZLOout,ZHIout,HIin,Loin}
  localparam logic [15:0] B_PCOUT  = 16'h8000, B_PCIN   = 16'h4000, B_INCPC  = 16'h2000,
                          B_MARIN  = 16'h1000, B_MDRIN  = 16'h0800, B_MDROUT = 16'h0400,
                          B_READ   = 16'h0200, B_IRIN   = 16'h0100, B_YIN    = 16'h0080,
                          B_ZIN    = 16'h0040, B_ZLOIN  = 16'h0020, B_ZHIIN  = 16'h0010,
                          B_ZLOOUT = 16'h0008, B_ZHIOUT = 16'h0004, B_HIIN   = 16'h0002,
                          B_LOIN   = 16'h0001;
  localparam logic [15:0] C_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_ZLOIN;
  localparam logic [15:0] C_T1 = B_ZLOOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [15:0] C_T2 = B_MDROUT | B_IRIN;

  logic [15:0] ctl;
  assign ctl = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
                Yin, Zin, ZLOin, ZHIin, ZLOout, ZHIout, HIin, Loin};

  control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .clk(clk), .clr(clr), .IR(IR),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .ZLOin(ZLOin), .ZHIin(ZHIin), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .HIin(HIin), .Loin(Loin),
    .ALUSelection(ALUSelection), .Run(Run)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output; ALUSelection only where alu_chk is set
  task automatic check(input string tag, input logic [15:0] rin_e, input logic [15:0] rout_e,
                       input logic [15:0] ctl_e, input logic [4:0] alu_e, input bit alu_chk,
                       input logic run_e);
    cmp({tag, ".Rin"},  32'(Rin),  32'(rin_e));
    cmp({tag, ".Rout"}, 32'(Rout), 32'(rout_e));
    cmp({tag, ".ctl"},  32'(ctl),  32'(ctl_e));
    cmp({tag, ".Run"},  32'(Run),  32'(run_e));
    if (alu_chk) cmp({tag, ".ALUSel"}, 32'(ALUSelection), 32'(alu_e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    mk_ir = {op, ra, rb, rc, 15'h0};
  endfunction

  // Common fetch T0 -> T1 -> T2, entered with the DUT already in T0
  task automatic fetch(input string tag);
    check({tag, ".T0"}, 16'h0, 16'h0, C_T0, 5'b0, 1'b1, 1'b1);
    step();
    check({tag, ".T1"}, 16'h0, 16'h0, C_T1, 5'b0, 1'b1, 1'b1);
    step();
    check({tag, ".T2"}, 16'h0, 16'h0, C_T2, 5'b0, 1'b1, 1'b1);
    step();
  endtask

  // Bus rule: at most one bus driver and at most one Rin bit in any cycle
  always @(negedge clk) begin
    if (bus_check_en) begin
      cmp("bus_drivers_le1",
          32'(($countones(Rout) + 32'(PCout) + 32'(MDRout) + 32'(ZLOout) + 32'(ZHIout)) <= 1),
          32'd1);
      cmp("rin_onehot0", 32'($countones(Rin) <= 1), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Test 1: reset held two cycles, then one RESET cycle, then T0
    clr = 1'b1;
    IR  = 32'h0;
    step();
    bus_check_en = 1'b1;
    check("rst1", 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0);
    step();
    check("rst2", 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0);
    clr = 1'b0;
    check("rst_hold", 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0);
    step();

    // Test 2: and R1 = R2 & R3
    IR = 32'h28918000;
    fetch("and");
    check("and.T3", 16'h0, 16'h0004, B_YIN, 5'b0, 1'b0, 1'b1);
    step();
    check("and.T4", 16'h0, 16'h0008, B_ZIN | B_ZLOIN, 5'b00101, 1'b1, 1'b1);
    step();
    check("and.T5", 16'h0002, 16'h0, B_ZLOOUT, 5'b0, 1'b0, 1'b1);
    step();

    // Test 3: mul Ra=R1, Rb=R2
    IR = 32'h78900000;
    fetch("mul");
    check("mul.T3", 16'h0, 16'h0002, B_YIN, 5'b0, 1'b0, 1'b1);
    step();
    check("mul.T4", 16'h0, 16'h0004, B_ZIN | B_ZLOIN | B_ZHIIN, 5'b01111, 1'b1, 1'b1);
    step();
    check("mul.T5", 16'h0, 16'h0, B_ZLOOUT | B_LOIN, 5'b0, 1'b0, 1'b1);
    step();
    check("mul.T6", 16'h0, 16'h0, B_ZHIOUT | B_HIIN, 5'b0, 1'b0, 1'b1);
    step();

    // neg R5 = -R6
    IR = mk_ir(5'b10001, 4'd5, 4'd6, 4'd0);
    fetch("neg");
    check("neg.T3", 16'h0, 16'h0040, B_ZIN | B_ZLOIN, 5'b10001, 1'b1, 1'b1);
    step();
    check("neg.T4", 16'h0020, 16'h0, B_ZLOOUT, 5'b0, 1'b0, 1'b1);
    step();

    // Test 5: clr pulsed in T4 of the and instruction aborts it before write-back
    IR = 32'h28918000;
    fetch("abort");
    check("abort.T3", 16'h0, 16'h0004, B_YIN, 5'b0, 1'b0, 1'b1);
    step();
    check("abort.T4", 16'h0, 16'h0008, B_ZIN | B_ZLOIN, 5'b00101, 1'b1, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("abort.rst", 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0);
    step();

    // Test 6: undefined op returns from T2 straight to T0
    IR = 32'hF8000000;
    fetch("undef");
    check("undef.next", 16'h0, 16'h0, C_T0, 5'b0, 1'b1, 1'b1);

    // nop behaves the same way
    IR = mk_ir(5'b11010, 4'd3, 4'd4, 4'd5);
    fetch("nop");

    // Test 4: halt parks with everything low until clr
    IR = 32'hD8000000;
    fetch("halt");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("halt.c%0d", i), 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0);
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("halt.rst", 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0);
    step();
    check("halt.restart", 16'h0, 16'h0, C_T0, 5'b0, 1'b1, 1'b1);

    bus_check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
